// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and default sizing for the BTB set array
//
// Purpose: flush FSM state encoding and the default geometry constants used by
//          btb_set_array and btb_flush_fsm.
// Ports:   none (package).
package btb_pkg;

   localparam int BTB_NUM_SETS = 8;
   localparam int BTB_WAYS     = 2;
   localparam int BTB_ENTRY_W  = 64;

   typedef enum logic [1:0] {
      FL_IDLE  = 2'd0,
      FL_SWEEP = 2'd1,
      FL_DONE  = 2'd2
   } flush_state_e;

endpackage

// File: rtl/btb_flush_fsm.sv
// rtl/btb_flush_fsm.sv - sequential one-set-per-cycle flush engine
//
// Purpose: on flush_req in IDLE, sweeps every set index once (clr_en/clr_idx),
//          then emits a one-cycle flush_done. Requests while busy are ignored.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_req    single-cycle request to clear the whole array
//   flush_busy   high in SWEEP and DONE
//   flush_done   one-cycle pulse after the last set is cleared
//   clr_en       clear the set addressed by clr_idx at the next edge
//   clr_idx      set index being cleared this cycle
module btb_flush_fsm
   import btb_pkg::*;
#(
   parameter  int NUM_SETS = BTB_NUM_SETS,
   localparam int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_req,
   output logic             flush_busy,
   output logic             flush_done,
   output logic             clr_en,
   output logic [IDX_W-1:0] clr_idx
);

   // One extra bit so the counter can never alias back to a low index.
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SETS - 1);

   flush_state_e     state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FL_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      flush_busy = 1'b1;
      flush_done = 1'b0;
      clr_en     = 1'b0;
      case (state)
         FL_IDLE: begin
            flush_busy = 1'b0;
            if (flush_req) begin
               state_nxt = FL_SWEEP;
               cnt_nxt   = '0;
            end
         end
         FL_SWEEP: begin
            clr_en = 1'b1;
            if (cnt == LAST_IDX) begin
               state_nxt = FL_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         FL_DONE: begin
            flush_done = 1'b1;
            state_nxt  = FL_IDLE;
         end
         default: begin
            flush_busy = 1'b0;
            state_nxt  = FL_IDLE;
            cnt_nxt    = '0;
         end
      endcase
   end

   assign clr_idx = cnt[IDX_W-1:0];

endmodule

// File: rtl/btb_set_array.sv
// rtl/btb_set_array.sv - NUM_SETS x WAYS branch target buffer storage array
//
// Purpose: per-way masked writes, a forwarded predict read port, a raw update
//          read port and a sequential flush. Optional per-way even parity is
//          enabled by defining BTB_PARITY_EN; otherwise rd_par_err is tied to 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears all sets)
//   rd_idx       predict-port set index
//   rd_set       predict-port data, forwards same-cycle accepted writes
//   upd_idx      update-port set index
//   upd_set      update-port data, raw array contents
//   wr_en        write request
//   wr_idx       write set index
//   wr_way_mask  per-way write enable, way k = wr_set[k*ENTRY_W +: ENTRY_W]
//   wr_set       write data
//   flush_req    single-cycle request to clear the whole array
//   flush_busy   sweep in progress
//   flush_done   one-cycle pulse after the last set is cleared
//   rd_par_err   per-way parity error on rd_set
module btb_set_array
   import btb_pkg::*;
#(
   parameter  int NUM_SETS = BTB_NUM_SETS,
   parameter  int WAYS     = BTB_WAYS,
   parameter  int ENTRY_W  = BTB_ENTRY_W,
   localparam int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [WAYS*ENTRY_W-1:0] rd_set,
   input  logic [IDX_W-1:0]        upd_idx,
   output logic [WAYS*ENTRY_W-1:0] upd_set,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [WAYS-1:0]         wr_way_mask,
   input  logic [WAYS*ENTRY_W-1:0] wr_set,
   input  logic                    flush_req,
   output logic                    flush_busy,
   output logic                    flush_done,
   output logic [WAYS-1:0]         rd_par_err
);

   logic [ENTRY_W-1:0] mem [NUM_SETS][WAYS];
   logic               clr_en;
   logic [IDX_W-1:0]   clr_idx;
   logic               wr_acc;
   logic [WAYS-1:0]    rd_fwd;

   btb_flush_fsm #(
      .NUM_SETS (NUM_SETS)
   ) u_flush (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_req  (flush_req),
      .flush_busy (flush_busy),
      .flush_done (flush_done),
      .clr_en     (clr_en),
      .clr_idx    (clr_idx)
   );

   // A flush request wins over a same-cycle write; writes are dropped while busy.
   assign wr_acc = wr_en & ~flush_busy & ~flush_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < WAYS; w++)
               mem[s][w] <= '0;
      end else begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < WAYS; w++)
               if (clr_en && clr_idx == IDX_W'(s))
                  mem[s][w] <= '0;
               else if (wr_acc && wr_idx == IDX_W'(s) && wr_way_mask[w])
                  mem[s][w] <= wr_set[w*ENTRY_W +: ENTRY_W];
      end
   end

   always_comb begin
      rd_set  = '0;
      upd_set = '0;
      rd_fwd  = '0;
      for (int w = 0; w < WAYS; w++) begin
         rd_fwd[w] = wr_acc && (rd_idx == wr_idx) && wr_way_mask[w];
         rd_set[w*ENTRY_W +: ENTRY_W]  = rd_fwd[w] ? wr_set[w*ENTRY_W +: ENTRY_W]
                                                   : mem[rd_idx][w];
         upd_set[w*ENTRY_W +: ENTRY_W] = mem[upd_idx][w];
      end
   end

`ifdef BTB_PARITY_EN
   logic [WAYS-1:0] par [NUM_SETS];

   // Cleared entries are all-zero data, so their stored parity is 0 as well.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++)
            par[s] <= '0;
      end else begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < WAYS; w++)
               if (clr_en && clr_idx == IDX_W'(s))
                  par[s][w] <= 1'b0;
               else if (wr_acc && wr_idx == IDX_W'(s) && wr_way_mask[w])
                  par[s][w] <= ^wr_set[w*ENTRY_W +: ENTRY_W];
      end
   end

   // Forwarded ways come straight from the write bus and cannot be corrupt.
   always_comb begin
      rd_par_err = '0;
      for (int w = 0; w < WAYS; w++)
         rd_par_err[w] = ~rd_fwd[w] & ((^mem[rd_idx][w]) ^ par[rd_idx][w]);
   end
`else
   assign rd_par_err = '0;
`endif

endmodule

// File: tb/tb_btb_set_array.sv
// tb/tb_btb_set_array.sv - scoreboard bench for btb_set_array
module tb_btb_set_array;

   localparam int N  = 8;
   localparam int W  = 2;
   localparam int EW = 64;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [2:0]     rd_idx = '0;
   logic [W*EW-1:0] rd_set;
   logic [2:0]     upd_idx = '0;
   logic [W*EW-1:0] upd_set;
   logic           wr_en = 1'b0;
   logic [2:0]     wr_idx = '0;
   logic [W-1:0]   wr_way_mask = '0;
   logic [W*EW-1:0] wr_set = '0;
   logic           flush_req = 1'b0;
   logic           flush_busy;
   logic           flush_done;
   logic [W-1:0]   rd_par_err;

   btb_set_array dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx      (rd_idx),
      .rd_set      (rd_set),
      .upd_idx     (upd_idx),
      .upd_set     (upd_set),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_way_mask (wr_way_mask),
      .wr_set      (wr_set),
      .flush_req   (flush_req),
      .flush_busy  (flush_busy),
      .flush_done  (flush_done),
      .rd_par_err  (rd_par_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              cyc;
      logic [W*EW-1:0] rd;
      logic [W*EW-1:0] upd;
      logic            busy;
      logic            done;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: array contents plus the cycle a flush was accepted.
   logic [EW-1:0] m [N][W];
   int            cyc = 0;
   int            fs = -1000;
   bit            flushing = 1'b0;

   function automatic logic [W*EW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push_exp(input logic we, input logic [2:0] widx, input logic [W-1:0] mask,
                           input logic [W*EW-1:0] wd, input logic freq, input logic [2:0] ridx,
                           input logic [2:0] uidx, input bit in_reset);
      exp_t e;
      logic busy, done, acc;
      busy = !in_reset && flushing && cyc >= fs + 1 && cyc <= fs + N + 1;
      done = !in_reset && flushing && cyc == fs + N + 1;
      acc  = !in_reset && we && !busy && !freq;
      e.cyc  = cyc;
      e.busy = busy;
      e.done = done;
      for (int k = 0; k < W; k++) begin
         e.rd[k*EW +: EW]  = (acc && ridx == widx && mask[k]) ? wd[k*EW +: EW] : m[ridx][k];
         e.upd[k*EW +: EW] = m[uidx][k];
      end
      q.push_back(e);
      if (!in_reset) begin
         // Flush accepted at cycle fs clears set j at the end of cycle fs+1+j.
         if (busy && cyc <= fs + N)
            for (int k = 0; k < W; k++) m[cyc - fs - 1][k] = '0;
         if (acc)
            for (int k = 0; k < W; k++) if (mask[k]) m[widx][k] = wd[k*EW +: EW];
         if (freq && !busy) begin
            fs = cyc;
            flushing = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic step(input logic we, input logic [2:0] widx, input logic [W-1:0] mask,
                       input logic [W*EW-1:0] wd, input logic freq, input logic [2:0] ridx,
                       input logic [2:0] uidx);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      wr_en       = we;
      wr_idx      = widx;
      wr_way_mask = mask;
      wr_set      = wd;
      flush_req   = freq;
      rd_idx      = ridx;
      upd_idx     = uidx;
      push_exp(we, widx, mask, wd, freq, ridx, uidx, 1'b0);
   endtask

   task automatic idle(input logic [2:0] ridx, input logic [2:0] uidx);
      step(1'b0, 3'd0, 2'b00, '0, 1'b0, ridx, uidx);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      flush_req = 1'b0;
      rd_idx    = 3'($urandom);
      upd_idx   = 3'($urandom);
      for (int s = 0; s < N; s++)
         for (int k = 0; k < W; k++) m[s][k] = '0;
      flushing = 1'b0;
      push_exp(1'b0, 3'd0, 2'b00, '0, 1'b0, rd_idx, upd_idx, 1'b1);
   endtask

   // Monitor: the DUT read ports are combinational, so every cycle presents output.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks += 5;
            if (rd_set !== e.rd) begin
               errors++;
               $display("FAIL rd_set cyc=%0d got=%h exp=%h", e.cyc, rd_set, e.rd);
            end
            if (upd_set !== e.upd) begin
               errors++;
               $display("FAIL upd_set cyc=%0d got=%h exp=%h", e.cyc, upd_set, e.upd);
            end
            if (flush_busy !== e.busy) begin
               errors++;
               $display("FAIL flush_busy cyc=%0d got=%b exp=%b", e.cyc, flush_busy, e.busy);
            end
            if (flush_done !== e.done) begin
               errors++;
               $display("FAIL flush_done cyc=%0d got=%b exp=%b", e.cyc, flush_done, e.done);
            end
            if (rd_par_err !== 2'b00) begin
               errors++;
               $display("FAIL rd_par_err cyc=%0d got=%b exp=00", e.cyc, rd_par_err);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached, queue=%0d", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W*EW-1:0] d;
      logic [2:0]      wi;
      for (int s = 0; s < N; s++)
         for (int k = 0; k < W; k++) m[s][k] = '0;

      // Reset state, then sweep both read ports across every index.
      do_reset();
      for (int s = 0; s < N; s++) idle(3'(s), 3'(N - 1 - s));

      // Single-way write with same-cycle forwarding, visible on upd_set next cycle.
      step(1'b1, 3'd3, 2'b01, {64'hB, 64'hA}, 1'b0, 3'd3, 3'd3);
      idle(3'd3, 3'd3);
      step(1'b1, 3'd3, 2'b00, rand_data(), 1'b0, 3'd3, 3'd3);
      step(1'b1, 3'd3, 2'b10, rand_data(), 1'b0, 3'd3, 3'd3);
      idle(3'd3, 3'd3);

      // Fill every set, flush, keep reading and attempting writes while busy.
      for (int s = 0; s < N; s++) step(1'b1, 3'(s), 2'b11, {W*EW{1'b1}}, 1'b0, 3'(s), 3'(s));
      step(1'b0, 3'd0, 2'b00, '0, 1'b1, 3'd7, 3'd0);
      for (int c = 0; c < N + 3; c++)
         step(1'($urandom), 3'($urandom), 2'($urandom), rand_data(),
              1'(c == 2), 3'($urandom), 3'($urandom));
      for (int s = 0; s < N; s++) idle(3'(s), 3'(s));

      // Flush and write in the same cycle: write dropped; write during busy dropped.
      step(1'b1, 3'd5, 2'b11, rand_data(), 1'b1, 3'd5, 3'd5);
      idle(3'd5, 3'd5);
      idle(3'd6, 3'd6);
      step(1'b1, 3'd6, 2'b11, rand_data(), 1'b0, 3'd6, 3'd6);
      for (int c = 0; c < N; c++) idle(3'd6, 3'd5);

      // Reset in the middle of a sweep: everything clears and no done pulse follows.
      for (int s = 0; s < N; s++) step(1'b1, 3'(s), 2'b11, rand_data(), 1'b0, 3'(s), 3'(s));
      step(1'b0, 3'd0, 2'b00, '0, 1'b1, 3'd4, 3'd7);
      for (int c = 0; c < 4; c++) idle(3'd7, 3'(c));
      do_reset();
      for (int s = 0; s < N + 4; s++) idle(3'(s), 3'(s));

      // Randomised traffic with occasional flushes.
      for (int c = 0; c < 600; c++) begin
         wi = 3'($urandom);
         d  = rand_data();
         step(1'($urandom), wi, 2'($urandom), d, 1'($urandom_range(0, 39) == 0),
              ($urandom_range(0, 1) == 1) ? wi : 3'($urandom), 3'($urandom));
      end
      for (int c = 0; c < N + 2; c++) idle(3'(c), 3'(c));

      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got=%0d entries exp=0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
